// File: rtl/sms_bus_pkg.sv
// Shared types and helpers for the dotted SMS line arbiter.
// Holds the FSM state enum, default counter width and pointer wrap.
package sms_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam int CNT_W_DEF = 8;

    // Advance a round-robin pointer by one, wrapping at n.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sms_rr_pick.sv
// Combinational round-robin picker for the dotted line arbiter.
// Scans req starting at ptr and returns the first set index.
module sms_rr_pick
    import sms_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // First requester at or after ptr in rotation order wins.
    always_comb begin
        int i;
        i     = 0;
        win   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            i = (int'(ptr) + k) % N_REQ;
            if (!valid && req[i]) begin
                valid  = 1'b1;
                win[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sms_dot_bus_arbiter.sv
// Round-robin owner of one wired-AND SMS line with bounded hold time.
// Optional contention monitor built when SMS_DOT_BUS_MONITOR_EN is defined.
module sms_dot_bus_arbiter
    import sms_bus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] drv_n,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             bus,
    output logic [N_REQ-1:0] timeout_err,
    output logic             contention,
    output logic [CNT_W-1:0] cont_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic [N_REQ-1:0] pick_win;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    sms_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Next state: arbitrate in IDLE, count hold in GRANT, one float cycle in GAP.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = pick_win;
                    own_d   = pick_idx;
                    hold_d  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[own_q] || hold_q == CNT_W'(HOLD_MAX)) begin
                    // Still requesting here means the hold limit forced release.
                    if (req[own_q]) begin
                        err_d[own_q] = 1'b1;
                    end
                    state_d = GAP;
                    gnt_d   = '0;
                    ptr_d   = IDX_W'(rr_next(int'(own_q), N_REQ));
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q == GRANT);
    assign timeout_err = err_q;
    // Only the granted driver can pull the dotted node low.
    assign bus         = ~|(gnt_q & ~drv_n);

`ifdef SMS_DOT_BUS_MONITOR_EN
    logic             cont_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    assign hit = |(~gnt_q & ~drv_n);

    // Flag and count cycles where an ungranted driver pulls low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cont_q <= hit;
            if (hit && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign contention = cont_q;
    assign cont_cnt   = cnt_q;
`else
    assign contention = 1'b0;
    assign cont_cnt   = '0;
`endif

endmodule

// File: tb/tb_sms_dot_bus_arbiter.sv
// Randomized bench for sms_dot_bus_arbiter with a cycle-level reference model.
// Directed scenarios first, then random req/drv_n/reset traffic.
module tb_sms_dot_bus_arbiter;

    localparam int N  = 4;
    localparam int HM = 15;
`ifdef SMS_DOT_BUS_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] drv_n = '1;
    logic [3:0] gnt;
    logic       busy;
    logic       bus;
    logic [3:0] timeout_err;
    logic       contention;
    logic [7:0] cont_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: current owner (-1 none), cycles owned,
    // pending float cycle, rotation start, sticky errors, monitor.
    int         m_owner = -1;
    int         m_hold = 0;
    bit         m_gap = 1'b0;
    int         m_ptr = 0;
    logic [3:0] m_err = '0;
    bit         m_cont = 1'b0;
    int         m_cnt = 0;

    sms_dot_bus_arbiter #(
        .N_REQ    (N),
        .HOLD_MAX (HM),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .drv_n       (drv_n),
        .gnt         (gnt),
        .busy        (busy),
        .bus         (bus),
        .timeout_err (timeout_err),
        .contention  (contention),
        .cont_cnt    (cont_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, want, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] d,
                              input logic rs);
        bit any_low;
        if (!rs) begin
            m_owner = -1;
            m_hold  = 0;
            m_gap   = 1'b0;
            m_ptr   = 0;
            m_err   = '0;
            m_cont  = 1'b0;
            m_cnt   = 0;
            return;
        end
        any_low = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i != m_owner && d[i] == 1'b0) any_low = 1'b1;
        end
        if (MON) begin
            m_cont = any_low;
            if (any_low && m_cnt < 255) m_cnt++;
        end
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_hold == HM) begin
                if (r[m_owner]) m_err[m_owner] = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_hold  = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        logic       eb;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        eb = (m_owner >= 0) ? drv_n[m_owner] : 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("bus", 32'(bus), 32'(eb));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("contention", 32'(contention), 32'(m_cont));
        check("cont_cnt", 32'(cont_cnt), 32'(m_cnt));
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] d,
                         input logic rs);
        req   = r;
        drv_n = d;
        rst_n = rs;
        @(posedge clk);
        model_step(r, d, rs);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int         gcount;
        logic [3:0] r;
        logic [3:0] d;
        logic       rs;

        cycle(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b0);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_bus", 32'(bus), 32'h1);

        cycle(4'b0101, 4'b1111, 1'b1);
        check("rr_first", 32'(gnt), 32'h1);
        cycle(4'b0100, 4'b1111, 1'b1);
        check("gap_gnt", 32'(gnt), 32'h0);
        cycle(4'b0100, 4'b1111, 1'b1);
        cycle(4'b0100, 4'b1111, 1'b1);
        check("rr_second", 32'(gnt), 32'h4);
        cycle(4'b0000, 4'b1111, 1'b1);
        cycle(4'b0000, 4'b1111, 1'b1);

        gcount = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0010, 4'b1111, 1'b1);
            if (i < 17 && gnt == 4'b0010) gcount++;
        end
        check("hold_len", 32'(gcount), 32'd15);
        check("timeout", 32'(timeout_err), 32'h2);
        cycle(4'b0000, 4'b1111, 1'b1);
        cycle(4'b0000, 4'b1111, 1'b1);

        cycle(4'b0001, 4'b1111, 1'b1);
        check("own0", 32'(gnt), 32'h1);
        cycle(4'b0001, 4'b1110, 1'b1);
        check("bus_low", 32'(bus), 32'h0);
        cycle(4'b0001, 4'b1111, 1'b1);
        check("bus_float", 32'(bus), 32'h1);
        cycle(4'b0001, 4'b1101, 1'b1);
        check("bus_mask", 32'(bus), 32'h1);
        cycle(4'b0001, 4'b1101, 1'b1);
        cycle(4'b0001, 4'b1101, 1'b1);
        check("cont_flag", 32'(contention), MON ? 32'h1 : 32'h0);
        check("cont_three", 32'(cont_cnt), MON ? 32'd3 : 32'd0);

        cycle(4'b0000, 4'b1111, 1'b1);
        cycle(4'b0000, 4'b1111, 1'b1);
        for (int i = 0; i < 7; i++) cycle(4'b0001, 4'b1111, 1'b1);
        cycle(4'b0001, 4'b1111, 1'b0);
        check("rst_mid_gnt", 32'(gnt), 32'h0);
        check("rst_err_clr", 32'(timeout_err), 32'h0);
        cycle(4'b1111, 4'b1111, 1'b1);
        check("rst_ptr0", 32'(gnt), 32'h1);

        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            d  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1111;
            rs = ($urandom_range(99) != 0);
            cycle(r, d, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
